// File: rtl/lmc_pkg.sv
// Shared constants and types for the LMC memory arbiter.
package lmc_pkg;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned WORD_W    = 11;
  localparam int unsigned MEM_DEPTH = 100;

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_HOST = 1'b1
  } lmc_port_t;

  // One slot of the read/error return pipeline.
  typedef struct packed {
    logic      valid;
    lmc_port_t port;
    logic      err;
  } ret_entry_t;

  function automatic lmc_port_t other_port(lmc_port_t p);
    return (p == PORT_CPU) ? PORT_HOST : PORT_CPU;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the pointer flips to the loser after every grant.
module rr_arb2
  import lmc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  lmc_port_t ptr_q, ptr_d;

  // Bit 0 is the CPU, bit 1 the host.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == PORT_CPU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = other_port(gnt[1] ? PORT_HOST : PORT_CPU);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= PORT_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lmc_mem_arbiter.sv
// Shares the single-port LMC memory between the CPU and the host loader port.
// Define LMC_ARB_STATS_EN to add saturating grant and conflict counters.
module lmc_mem_arbiter #(
  parameter int unsigned ADDR_W    = lmc_pkg::ADDR_W,
  parameter int unsigned WORD_W    = lmc_pkg::WORD_W,
  parameter int unsigned MEM_DEPTH = lmc_pkg::MEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic signed [WORD_W-1:0] cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic signed [WORD_W-1:0] cpu_rdata,
  output logic                     cpu_err,

  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic signed [WORD_W-1:0] host_wdata,
  output logic                     host_gnt,
  output logic                     host_rvalid,
  output logic signed [WORD_W-1:0] host_rdata,
  output logic                     host_err,

  input  logic                     host_hold,
  output logic                     cpu_stalled,

  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic signed [WORD_W-1:0] mem_wdata,
`ifdef LMC_ARB_STATS_EN
  output logic [15:0]              cpu_grant_cnt,
  output logic [15:0]              host_grant_cnt,
  output logic [15:0]              conflict_cnt,
`endif
  input  logic signed [WORD_W-1:0] mem_rdata
);

  logic [1:0]               elig;
  logic [1:0]               arb_gnt;
  logic                     accept;
  logic                     acc_host;
  logic                     acc_we;
  logic                     acc_in_range;
  logic [ADDR_W-1:0]        acc_addr;
  logic signed [WORD_W-1:0] acc_wdata;
  logic                     ret_cpu;
  logic                     ret_host;

  lmc_pkg::ret_entry_t ret_d, ret_q;

  // A held CPU is simply not a candidate, so the pointer is untouched by the hold itself.
  assign elig = {host_req, cpu_req & ~host_hold};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .advance (accept),
    .gnt     (arb_gnt)
  );

  assign cpu_gnt  = arb_gnt[0] & reset;
  assign host_gnt = arb_gnt[1] & reset;
  assign accept   = cpu_gnt | host_gnt;
  assign acc_host = host_gnt;

  always_comb begin
    acc_we    = cpu_we;
    acc_addr  = cpu_addr;
    acc_wdata = cpu_wdata;
    if (acc_host) begin
      acc_we    = host_we;
      acc_addr  = host_addr;
      acc_wdata = host_wdata;
    end
  end

  assign acc_in_range = 32'(acc_addr) < MEM_DEPTH;

  // Reads always return; writes return only to report a bad address.
  always_comb begin
    ret_d       = '0;
    ret_d.valid = accept & (~acc_we | ~acc_in_range);
    ret_d.port  = acc_host ? lmc_pkg::PORT_HOST : lmc_pkg::PORT_CPU;
    ret_d.err   = ~acc_in_range;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept & acc_in_range & acc_we;
      if (accept && acc_in_range) begin
        mem_addr  <= acc_addr;
        mem_wdata <= acc_wdata;
      end
    end
  end

  assign ret_cpu  = ret_q.valid && (ret_q.port == lmc_pkg::PORT_CPU);
  assign ret_host = ret_q.valid && (ret_q.port == lmc_pkg::PORT_HOST);

  // mem_rdata belongs to the access in ret_q; capture it into the owner's rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_q       <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      ret_q       <= ret_d;
      cpu_rvalid  <= ret_cpu;
      cpu_err     <= ret_cpu & ret_q.err;
      host_rvalid <= ret_host;
      host_err    <= ret_host & ret_q.err;
      if (ret_cpu) begin
        cpu_rdata <= ret_q.err ? '0 : mem_rdata;
      end
      if (ret_host) begin
        host_rdata <= ret_q.err ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_stalled <= 1'b0;
    end else begin
      cpu_stalled <= cpu_req & ~cpu_gnt;
    end
  end

`ifdef LMC_ARB_STATS_EN
  logic conflict;

  assign conflict = (elig == 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_grant_cnt  <= '0;
      host_grant_cnt <= '0;
      conflict_cnt   <= '0;
    end else begin
      if (cpu_gnt && cpu_grant_cnt != 16'hFFFF) begin
        cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      end
      if (host_gnt && host_grant_cnt != 16'hFFFF) begin
        host_grant_cnt <= host_grant_cnt + 16'd1;
      end
      if (conflict && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lmc_mem_arbiter.sv
// Self-checking bench for lmc_mem_arbiter with a transaction-level reference model.
module tb_lmc_mem_arbiter;

  localparam int AW    = 7;
  localparam int WW    = 11;
  localparam int DEPTH = 100;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
  logic [AW-1:0]        cpu_addr;
  logic signed [WW-1:0] cpu_wdata, cpu_rdata;
  logic                 host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [AW-1:0]        host_addr;
  logic signed [WW-1:0] host_wdata, host_rdata;
  logic                 host_hold, cpu_stalled;
  logic [AW-1:0]        mem_addr;
  logic                 mem_we;
  logic signed [WW-1:0] mem_wdata, mem_rdata;
`ifdef LMC_ARB_STATS_EN
  logic [15:0]          cpu_grant_cnt, host_grant_cnt, conflict_cnt;
`endif

  lmc_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_err    (host_err),
    .host_hold   (host_hold),
    .cpu_stalled (cpu_stalled),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
`ifdef LMC_ARB_STATS_EN
    .cpu_grant_cnt  (cpu_grant_cnt),
    .host_grant_cnt (host_grant_cnt),
    .conflict_cnt   (conflict_cnt),
`endif
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory instance: combinational read of the registered address, write on the edge.
  logic signed [WW-1:0] mem [0:127];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model: transaction level, returns scheduled by due cycle.
  typedef struct {
    int                   due;
    bit                   host;
    bit                   err;
    logic signed [WW-1:0] data;
  } ret_t;

  ret_t                 ret_q[$];
  logic signed [WW-1:0] ref_mem [0:DEPTH-1];
  bit                   ptr_host;
  int                   cyc;
  bit                   e_cgnt, e_hgnt, e_crv, e_cerr, e_hrv, e_herr, e_stall, e_we;
  logic [AW-1:0]        e_addr;
  logic signed [WW-1:0] e_wdata, e_crdata, e_hrdata;
  int                   n_checks = 0;
  int                   n_errors = 0;

  function automatic void model_reset();
    ret_q.delete();
    ptr_host = 1'b0;
    {e_cgnt, e_hgnt, e_crv, e_cerr, e_hrv, e_herr, e_stall, e_we} = '0;
    e_addr   = '0;
    e_wdata  = '0;
    e_crdata = '0;
    e_hrdata = '0;
  endfunction

  function automatic void predict();
    bit ce, he;
    ce = cpu_req && !host_hold;
    he = host_req;
    e_cgnt = 1'b0;
    e_hgnt = 1'b0;
    if (reset) begin
      if (ce && he) begin
        e_hgnt = ptr_host;
        e_cgnt = !ptr_host;
      end else begin
        e_cgnt = ce;
        e_hgnt = he;
      end
    end
  endfunction

  task automatic set_cpu(bit r, bit we, logic [AW-1:0] a, logic signed [WW-1:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(bit r, bit we, logic [AW-1:0] a, logic signed [WW-1:0] d);
    host_req = r; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic half();
    predict();
    @(negedge clk);
  endtask

  // Commits the cycle's accepted access to the model, then moves to just after the edge.
  task automatic clock_edge();
    bit                   hostp, we;
    logic [AW-1:0]        a;
    logic signed [WW-1:0] d;
    ret_t                 r;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      hostp   = e_hgnt;
      we      = hostp ? host_we : cpu_we;
      a       = hostp ? host_addr : cpu_addr;
      d       = hostp ? host_wdata : cpu_wdata;
      e_stall = cpu_req && !e_cgnt;
      e_we    = 1'b0;
      if (e_cgnt || e_hgnt) begin
        if (int'(a) < DEPTH) begin
          e_we    = we;
          e_addr  = a;
          e_wdata = d;
          if (we) ref_mem[a] = d;
          else ret_q.push_back('{cyc + 1, hostp, 1'b0, ref_mem[a]});
        end else begin
          ret_q.push_back('{cyc + 1, hostp, 1'b1, '0});
        end
        ptr_host = !hostp;
      end
      {e_crv, e_cerr, e_hrv, e_herr} = '0;
      while (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        if (r.host) begin e_hrv = 1'b1; e_herr = r.err; e_hrdata = r.data; end
        else begin e_crv = 1'b1; e_cerr = r.err; e_crdata = r.data; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_cpu(1, 0, 7'd3, 0);
    set_host(1, 1, 7'd4, 11'sd9);
    host_hold = 1'b0;
    model_reset();
    half();
    n_checks++;
    if ({cpu_gnt, host_gnt} !== 2'b00) begin
      n_errors++; $display("FAIL reset_gnt: got %b expected 00", {cpu_gnt, host_gnt});
    end
    n_checks++;
    if ({cpu_rvalid, cpu_err, host_rvalid, host_err, cpu_stalled, mem_we} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {cpu_rvalid, cpu_err, host_rvalid, host_err, cpu_stalled, mem_we});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, host_rdata} !== '0) begin
      n_errors++; $display("FAIL reset_data: got addr %0d wdata %0d crd %0d hrd %0d expected 0",
                           mem_addr, mem_wdata, cpu_rdata, host_rdata);
    end
    clock_edge();
    set_cpu(0, 0, 0, 0);
    set_host(0, 0, 0, 0);
    reset = 1'b1;
    half();
    clock_edge();
  endtask

  task automatic test_write_read();
    set_cpu(1, 1, 7'd42, 11'sd500);
    half();
    n_checks++;
    if ({cpu_gnt, host_gnt} !== 2'b10) begin
      n_errors++; $display("FAIL wr_gnt: got %b expected 10", {cpu_gnt, host_gnt});
    end
    clock_edge();
    set_cpu(0, 0, 0, 0);
    set_host(1, 0, 7'd42, 0);
    half();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd42 || mem_wdata !== 11'sd500) begin
      n_errors++; $display("FAIL wr_mem: got we %b addr %0d data %0d expected 1 42 500",
                           mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if (host_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL rd_gnt: got hgnt %b crv %b expected 1 0", host_gnt, cpu_rvalid);
    end
    clock_edge();
    set_host(0, 0, 0, 0);
    half();
    n_checks++;
    if (host_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL wr_norv: got hrv %b crv %b expected 0 0", host_rvalid, cpu_rvalid);
    end
    clock_edge();
    half();
    n_checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 11'sd500 || host_err !== 1'b0 || cpu_rvalid !== 1'b0)
    begin
      n_errors++; $display("FAIL rd_ret: got hrv %b hrd %0d herr %b crv %b expected 1 500 0 0",
                           host_rvalid, host_rdata, host_err, cpu_rvalid);
    end
    clock_edge();
  endtask

  task automatic test_alternate();
    set_cpu(1, 0, 7'd42, 0);
    set_host(1, 0, 7'd10, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        set_cpu(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
      end
      half();
      if (i < 6) begin
        n_checks++;
        if ({cpu_gnt, host_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_errors++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, {cpu_gnt, host_gnt},
                               (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      n_checks++;
      if (cpu_stalled !== e_stall || cpu_rvalid !== e_crv || host_rvalid !== e_hrv) begin
        n_errors++; $display("FAIL alt_ret[%0d]: got stall %b crv %b hrv %b expected %b %b %b",
                             i, cpu_stalled, cpu_rvalid, host_rvalid, e_stall, e_crv, e_hrv);
      end
      clock_edge();
    end
  endtask

  task automatic test_hold();
    host_hold = 1'b1;
    set_cpu(1, 0, 7'd1, 0);
    set_host(1, 0, 7'd2, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) host_hold = 1'b0;
      half();
      n_checks++;
      if ({cpu_gnt, host_gnt} !== ((i == 4) ? 2'b10 : 2'b01)) begin
        n_errors++; $display("FAIL hold_gnt[%0d]: got %b expected %b", i, {cpu_gnt, host_gnt},
                             (i == 4) ? 2'b10 : 2'b01);
      end
      clock_edge();
    end
    set_cpu(0, 0, 0, 0);
    set_host(0, 0, 0, 0);
    half();
    clock_edge();
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] addr_before;
    set_cpu(1, 0, 7'd105, 0);
    half();
    addr_before = e_addr;
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_errors++; $display("FAIL oor_gnt: got %b expected 1", cpu_gnt);
    end
    clock_edge();
    set_cpu(0, 0, 0, 0);
    half();
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== addr_before) begin
      n_errors++; $display("FAIL oor_mem: got we %b addr %0d expected 0 %0d",
                           mem_we, mem_addr, addr_before);
    end
    clock_edge();
    half();
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 11'sd0) begin
      n_errors++; $display("FAIL oor_ret: got rv %b err %b rd %0d expected 1 1 0",
                           cpu_rvalid, cpu_err, cpu_rdata);
    end
    clock_edge();
  endtask

  task automatic test_reset_inflight();
    set_host(1, 0, 7'd42, 0);
    half();
    clock_edge();
    set_host(0, 0, 0, 0);
    set_cpu(1, 0, 7'd5, 0);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_stalled, mem_we, mem_addr, mem_wdata,
         cpu_rdata, host_rdata} !== '0) begin
      n_errors++; $display("FAIL rst_async: got gnt %b%b addr %0d hrd %0d expected all 0",
                           cpu_gnt, host_gnt, mem_addr, host_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      half();
      n_checks++;
      if ({cpu_gnt, host_gnt, host_rvalid, host_err} !== 4'b0) begin
        n_errors++; $display("FAIL rst_hold[%0d]: got %b expected 0000", i,
                             {cpu_gnt, host_gnt, host_rvalid, host_err});
      end
      clock_edge();
    end
    reset = 1'b1;
    set_cpu(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      half();
      n_checks++;
      if (host_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
        n_errors++; $display("FAIL rst_norv[%0d]: got hrv %b crv %b expected 0 0", i,
                             host_rvalid, cpu_rvalid);
      end
      clock_edge();
    end
    set_cpu(1, 0, 7'd6, 0);
    set_host(1, 0, 7'd7, 0);
    half();
    n_checks++;
    if ({cpu_gnt, host_gnt} !== 2'b10) begin
      n_errors++; $display("FAIL rst_ptr: got %b expected 10", {cpu_gnt, host_gnt});
    end
    clock_edge();
    set_cpu(0, 0, 0, 0);
    set_host(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin half(); clock_edge(); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // A pending request keeps its fields until it has been granted.
      if (!cpu_req || e_cgnt)
        set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                7'($urandom_range(0, 119)), 11'($urandom));
      if (!host_req || e_hgnt)
        set_host($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 7'($urandom_range(0, 119)), 11'($urandom));
      host_hold = ($urandom_range(0, 4) == 0);
      half();
      n_checks++;
      if ({cpu_gnt, host_gnt} !== {e_cgnt, e_hgnt}) begin
        n_errors++; $display("FAIL rnd_gnt @%0d: got %b expected %b", cyc,
                             {cpu_gnt, host_gnt}, {e_cgnt, e_hgnt});
      end
      n_checks++;
      if ({cpu_rvalid, cpu_err, host_rvalid, host_err, cpu_stalled} !==
          {e_crv, e_cerr, e_hrv, e_herr, e_stall}) begin
        n_errors++; $display("FAIL rnd_flags @%0d: got %b expected %b", cyc,
                             {cpu_rvalid, cpu_err, host_rvalid, host_err, cpu_stalled},
                             {e_crv, e_cerr, e_hrv, e_herr, e_stall});
      end
      n_checks++;
      if (cpu_rdata !== e_crdata || host_rdata !== e_hrdata) begin
        n_errors++; $display("FAIL rnd_rdata @%0d: got %0d %0d expected %0d %0d", cyc,
                             cpu_rdata, host_rdata, e_crdata, e_hrdata);
      end
      n_checks++;
      if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        n_errors++; $display("FAIL rnd_mem @%0d: got %b %0d %0d expected %b %0d %0d", cyc,
                             mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
      end
      clock_edge();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cyc = 0;
    test_reset();
    test_write_read();
    test_alternate();
    test_hold();
    test_out_of_range();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
